seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for NUM_DIGITS common-bus
//             7-segment digits. Holds one BCD value plus decimal point per
//             digit, accepts updates on a valid/ready write port and walks the
//             digit selects one slot at a time, blanking at the start of each
//             slot to suppress ghosting.
//  Ports    : clk        - single clock
//             rst        - asynchronous, active-high reset
//             enable     - 1 = scan running, 0 = display dark
//             wr_valid   - write request
//             wr_ready   - write accepted on an edge where wr_valid & wr_ready
//             wr_digit   - target digit index (out-of-range writes are dropped)
//             wr_value   - BCD value for the digit
//             wr_dp      - decimal point for the digit
//             seg        - segment bus {a,b,c,d,e,f,g,dp}, registered
//             dig_sel    - one-hot digit select, registered
//             frame_done - one-cycle pulse after a full scan of all digits
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int BLANK_CYC  = 8,
   parameter int DW         = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DW-1:0]         wr_digit,
   input  logic [3:0]            wr_value,
   input  logic                  wr_dp,
   output logic [7:0]            seg,
   output logic [NUM_DIGITS-1:0] dig_sel,
   output logic                  frame_done
);

   localparam int            CW           = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] C_BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] C_SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] C_IDX_LAST   = DW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_SHOW  = 2'd2
   } state_t;

   state_t                  r_state;
   logic [DW-1:0]           r_idx;
   logic [CW-1:0]           r_cnt;
   logic [7:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_dig_sel;
   logic                    r_frame_done;
   logic                    r_ready;

   logic [3:0]              r_val [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   r_dp;

   logic                    w_wr_fire;
   logic [3:0]              w_cur_val;
   logic                    w_cur_dp;
   logic [NUM_DIGITS-1:0]   w_onehot;
   logic                    w_bypass;
   logic [7:0]              w_show_seg;

   // Segment pattern for one digit; non-BCD values go fully dark, dp included.
   function automatic logic [7:0] f_decode(input logic [3:0] v, input logic dp);
      logic [7:0] s;
      case (v)
         4'd0:    s = 8'hFC;
         4'd1:    s = 8'h60;
         4'd2:    s = 8'hDA;
         4'd3:    s = 8'hF2;
         4'd4:    s = 8'h66;
         4'd5:    s = 8'hB6;
         4'd6:    s = 8'hBE;
         4'd7:    s = 8'hE0;
         4'd8:    s = 8'hFE;
         4'd9:    s = 8'hE6;
         default: s = 8'h00;
      endcase
      if (v <= 4'd9) begin
         s[0] = dp;
      end
      return s;
   endfunction

   assign w_wr_fire = wr_valid & r_ready;

   // Digit store. Indices at or above NUM_DIGITS match no entry and are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_val[i] <= 4'd0;
         end
         r_dp <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_wr_fire && (wr_digit == DW'(i))) begin
               r_val[i] <= wr_value;
               r_dp[i]  <= wr_dp;
            end
         end
      end
   end

   // Current entry and one-hot select for the slot index.
   always_comb begin
      w_cur_val = 4'd0;
      w_cur_dp  = 1'b0;
      w_onehot  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == DW'(i)) begin
            w_cur_val   = r_val[i];
            w_cur_dp    = r_dp[i];
            w_onehot[i] = 1'b1;
         end
      end
   end

   // A write landing on the SHOW-entry edge for this same digit must be the
   // value latched for the slot, so bypass the store.
   assign w_bypass   = w_wr_fire && (wr_digit == r_idx);
   assign w_show_seg = w_bypass ? f_decode(wr_value, wr_dp)
                                : f_decode(w_cur_val, w_cur_dp);

   // Scan FSM with registered outputs. wr_ready is computed from the state
   // being entered so it lines up with the state in every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_seg        <= 8'h00;
         r_dig_sel    <= '0;
         r_frame_done <= 1'b0;
         r_ready      <= 1'b0;
      end else if (!enable) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_seg        <= 8'h00;
         r_dig_sel    <= '0;
         r_frame_done <= 1'b0;
         r_ready      <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state      <= S_BLANK;
               r_idx        <= '0;
               r_cnt        <= '0;
               r_seg        <= 8'h00;
               r_dig_sel    <= '0;
               r_frame_done <= 1'b0;
               r_ready      <= 1'b1;
            end
            S_BLANK: begin
               r_frame_done <= 1'b0;
               r_cnt        <= r_cnt + CW'(1);
               if (r_cnt == C_BLANK_LAST) begin
                  r_state   <= S_SHOW;
                  r_seg     <= w_show_seg;
                  r_dig_sel <= w_onehot;
                  r_ready   <= 1'b0;
               end
            end
            S_SHOW: begin
               if (r_cnt == C_SLOT_LAST) begin
                  r_state      <= S_BLANK;
                  r_cnt        <= '0;
                  r_idx        <= (r_idx == C_IDX_LAST) ? '0 : r_idx + DW'(1);
                  r_frame_done <= (r_idx == C_IDX_LAST);
                  r_seg        <= 8'h00;
                  r_dig_sel    <= '0;
                  r_ready      <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_idx        <= '0;
               r_cnt        <= '0;
               r_seg        <= 8'h00;
               r_dig_sel    <= '0;
               r_frame_done <= 1'b0;
               r_ready      <= 1'b1;
            end
         endcase
      end
   end

   assign seg        = r_seg;
   assign dig_sel    = r_dig_sel;
   assign frame_done = r_frame_done;
   assign wr_ready   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Purpose  : Self-checking bench for seg7_scan_ctrl. Three instances:
//             4 digits / 10-cycle slots / 2 blank, 3 digits / 10 / 2, and the
//             default 4 / 1000 / 8 for slot and frame period timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

   logic       clk;
   logic       rst;

   // Main instance (NUM_DIGITS=4, SCAN_DIV=10, BLANK_CYC=2)
   logic       en, wv, wdp, rdy, fd;
   logic [1:0] wd;
   logic [3:0] wval;
   logic [7:0] seg;
   logic [3:0] sel;

   // Three-digit instance
   logic       en3, wv3, wdp3, rdy3, fd3;
   logic [1:0] wd3;
   logic [3:0] wval3;
   logic [7:0] seg3;
   logic [2:0] sel3;

   // Default-parameter instance
   logic       en_d, rdy_d, fd_d;
   logic [7:0] seg_d;
   logic [3:0] sel_d;

   int checks = 0;
   int errors = 0;
   int kpos   = 0;

   seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(10), .BLANK_CYC(2)) u_dut (
      .clk(clk), .rst(rst), .enable(en), .wr_valid(wv), .wr_ready(rdy),
      .wr_digit(wd), .wr_value(wval), .wr_dp(wdp), .seg(seg), .dig_sel(sel),
      .frame_done(fd)
   );

   seg7_scan_ctrl #(.NUM_DIGITS(3), .SCAN_DIV(10), .BLANK_CYC(2)) u_dut3 (
      .clk(clk), .rst(rst), .enable(en3), .wr_valid(wv3), .wr_ready(rdy3),
      .wr_digit(wd3), .wr_value(wval3), .wr_dp(wdp3), .seg(seg3),
      .dig_sel(sel3), .frame_done(fd3)
   );

   seg7_scan_ctrl u_dflt (
      .clk(clk), .rst(rst), .enable(en_d), .wr_valid(1'b0), .wr_ready(rdy_d),
      .wr_digit(2'd0), .wr_value(4'd0), .wr_dp(1'b0), .seg(seg_d),
      .dig_sel(sel_d), .frame_done(fd_d)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0] dig;
      logic [3:0] val;
      logic       dp;
      logic [7:0] exp_seg;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      kpos++;
   endtask

   task automatic run_to(input int t);
      while (kpos < t) step();
   endtask

   // Restart the main scan; returns at the negedge of the first BLANK cycle.
   task automatic start_scan();
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      kpos = 0;
   endtask

   task automatic do_write(input logic [1:0] d, input logic [3:0] v, input logic p,
                           output int waited);
      wd = d; wval = v; wdp = p; wv = 1'b1;
      waited = 0;
      while (!rdy && waited < 2000) begin
         step();
         waited++;
      end
      step();
      wv = 1'b0;
   endtask

   initial begin
      int         w;
      logic [7:0] exp_seg;
      logic [3:0] exp_sel;
      logic [7:0] scan_tab [4];
      logic [7:0] tab3 [3];
      int         t_show0, t_off0, t_show1, fd1, fd2, nfd;

      vecs[0]  = '{2'd0, 4'd0,  1'b0, 8'hFC};
      vecs[1]  = '{2'd1, 4'd5,  1'b1, 8'hB7};
      vecs[2]  = '{2'd2, 4'd6,  1'b0, 8'hBE};
      vecs[3]  = '{2'd3, 4'd7,  1'b0, 8'hE0};
      vecs[4]  = '{2'd0, 4'd8,  1'b1, 8'hFF};
      vecs[5]  = '{2'd1, 4'd9,  1'b0, 8'hE6};
      vecs[6]  = '{2'd2, 4'd10, 1'b1, 8'h00};
      vecs[7]  = '{2'd3, 4'd12, 1'b1, 8'h00};
      vecs[8]  = '{2'd0, 4'd15, 1'b0, 8'h00};
      vecs[9]  = '{2'd1, 4'd2,  1'b1, 8'hDB};
      vecs[10] = '{2'd2, 4'd4,  1'b0, 8'h66};
      vecs[11] = '{2'd3, 4'd3,  1'b1, 8'hF3};
      vecs[12] = '{2'd0, 4'd1,  1'b1, 8'h61};
      vecs[13] = '{2'd1, 4'd11, 1'b0, 8'h00};
      scan_tab[0] = 8'h60; scan_tab[1] = 8'hDA; scan_tab[2] = 8'hF3; scan_tab[3] = 8'h66;
      tab3[0] = 8'h60; tab3[1] = 8'hDA; tab3[2] = 8'hF2;

      rst = 1'b1;
      en = 1'b0; wv = 1'b0; wd = 2'd0; wval = 4'd0; wdp = 1'b0;
      en3 = 1'b0; wv3 = 1'b0; wd3 = 2'd0; wval3 = 4'd0; wdp3 = 1'b0;
      en_d = 1'b0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      chk("reset seg", seg, 8'h00);
      chk("reset dig_sel", sel, 4'h0);
      chk("reset frame_done", fd, 1'b0);
      chk("reset wr_ready", rdy, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("wr_ready after reset", rdy, 1'b1);

      // ---- writes while disabled ----
      do_write(2'd0, 4'd1, 1'b0, w); chk("idle write0 wait", w, 0);
      do_write(2'd1, 4'd2, 1'b0, w); chk("idle write1 wait", w, 0);
      do_write(2'd2, 4'd3, 1'b1, w); chk("idle write2 wait", w, 0);
      do_write(2'd3, 4'd4, 1'b0, w); chk("idle write3 wait", w, 0);
      chk("idle seg", seg, 8'h00);
      chk("idle dig_sel", sel, 4'h0);

      // ---- scan sequence: two full frames, cycle by cycle ----
      start_scan();
      for (int k = 0; k < 80; k++) begin
         run_to(k);
         if ((k % 10) < 2) begin
            exp_sel = 4'h0;
            exp_seg = 8'h00;
         end else begin
            exp_sel = 4'b0001 << ((k / 10) % 4);
            exp_seg = scan_tab[(k / 10) % 4];
         end
         chk($sformatf("scan dig_sel k=%0d", k), sel, exp_sel);
         chk($sformatf("scan seg k=%0d", k), seg, exp_seg);
         chk($sformatf("scan wr_ready k=%0d", k), rdy, ((k % 10) < 2) ? 1'b1 : 1'b0);
         chk($sformatf("scan frame_done k=%0d", k), fd, (k == 40) ? 1'b1 : 1'b0);
      end

      // ---- write stalled during SHOW of digit 1 ----
      start_scan();
      run_to(13);
      do_write(2'd0, 4'd9, 1'b0, w);
      chk("stall wait cycles", w, 7);
      run_to(42);
      chk("stalled write seg", seg, 8'hE6);
      chk("stalled write dig_sel", sel, 4'b0001);

      // ---- write on the SHOW-entry edge of digit 1 ----
      run_to(51);
      wd = 2'd1; wval = 4'd7; wdp = 1'b1; wv = 1'b1;
      step();
      wv = 1'b0;
      chk("bypass seg", seg, 8'hE1);
      chk("bypass dig_sel", sel, 4'b0010);
      run_to(59);
      chk("bypass seg held", seg, 8'hE1);

      // ---- table: write in BLANK, observe in the following SHOW ----
      for (int i = 0; i < 14; i++) begin
         start_scan();
         wd = vecs[i].dig; wval = vecs[i].val; wdp = vecs[i].dp; wv = 1'b1;
         step();
         wv = 1'b0;
         run_to(10 * int'(vecs[i].dig) + 2);
         exp_sel = 4'b0001 << vecs[i].dig;
         chk($sformatf("vec%0d seg", i), seg, vecs[i].exp_seg);
         chk($sformatf("vec%0d dig_sel", i), sel, exp_sel);
      end

      // ---- enable drop mid-SHOW and restart ----
      start_scan();
      run_to(5);
      en = 1'b0;
      @(negedge clk);
      chk("disable seg", seg, 8'h00);
      chk("disable dig_sel", sel, 4'h0);
      en = 1'b1;
      @(negedge clk);
      kpos = 0;
      chk("reenable blank dig_sel", sel, 4'h0);
      run_to(2);
      chk("reenable first digit", sel, 4'b0001);

      // ---- asynchronous reset mid-SHOW ----
      run_to(15);
      #2 rst = 1'b1;
      #1;
      chk("async rst seg", seg, 8'h00);
      chk("async rst dig_sel", sel, 4'h0);
      chk("async rst wr_ready", rdy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      kpos = 0;
      chk("post rst wr_ready", rdy, 1'b1);
      for (int d = 0; d < 4; d++) begin
         run_to(10 * d + 2);
         exp_sel = 4'b0001 << d;
         chk($sformatf("post rst seg d%0d", d), seg, 8'hFC);
         chk($sformatf("post rst dig_sel d%0d", d), sel, exp_sel);
      end

      // ---- three-digit instance: out-of-range index is dropped ----
      for (int d = 0; d < 4; d++) begin
         wd3 = 2'(d);
         wval3 = (d == 3) ? 4'd8 : 4'(d + 1);
         wdp3 = 1'b0;
         wv3 = 1'b1;
         chk($sformatf("n3 wr_ready d%0d", d), rdy3, 1'b1);
         @(negedge clk);
      end
      wv3 = 1'b0;
      en3 = 1'b1;
      for (int k = 0; k <= 30; k++) begin
         @(negedge clk);
         if ((k % 10) == 5 && k < 30) begin
            chk($sformatf("n3 dig_sel k=%0d", k), sel3, 3'b001 << (k / 10));
            chk($sformatf("n3 seg k=%0d", k), seg3, tab3[k / 10]);
         end
         if (k == 30) begin
            chk("n3 frame_done wrap", fd3, 1'b1);
            chk("n3 blank after wrap", sel3, 3'b000);
         end
      end

      // ---- default parameters: slot, blank and frame period ----
      t_show0 = -1; t_off0 = -1; t_show1 = -1; fd1 = -1; fd2 = -1; nfd = 0;
      en_d = 1'b1;
      for (int k = 0; k <= 8001; k++) begin
         @(negedge clk);
         if (k == 0) chk("dflt wr_ready in blank", rdy_d, 1'b1);
         if (k == 500) chk("dflt seg digit0", seg_d, 8'hFC);
         if (t_show0 < 0 && sel_d != 4'h0) t_show0 = k;
         else if (t_show0 >= 0 && t_off0 < 0 && sel_d == 4'h0) t_off0 = k;
         else if (t_off0 >= 0 && t_show1 < 0 && sel_d != 4'h0) t_show1 = k;
         if (fd_d) begin
            nfd++;
            if (fd1 < 0) fd1 = k;
            else if (fd2 < 0) fd2 = k;
         end
      end
      chk("dflt first show", t_show0, 8);
      chk("dflt slot length", t_show1 - t_show0, 1000);
      chk("dflt blank length", t_show1 - t_off0, 8);
      chk("dflt first frame_done", fd1, 4000);
      chk("dflt frame period", fd2 - fd1, 4000);
      chk("dflt frame_done count", nfd, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
